// File: rtl/amber_branch_unit_p_pkg.sv
// Shared definitions for the amber branch unit: opcodes, condition codes,
// flag bit positions and the condition evaluator.
package amber_branch_unit_p_pkg;

   // Branch-unit operation encodings
   typedef enum logic [2:0] {
      OpNop  = 3'd0,
      OpLui  = 3'd1,
      OpJcc  = 3'd2,
      OpBccr = 3'd3,
      OpBcco = 3'd4,
      OpBal  = 3'd5,
      OpCall = 3'd6,
      OpRet  = 3'd7
   } op_e;

   // Condition-code encodings
   typedef enum logic [3:0] {
      CcAl = 4'd0,
      CcEq = 4'd1,
      CcNe = 4'd2,
      CcCs = 4'd3,
      CcCc = 4'd4,
      CcMi = 4'd5,
      CcPl = 4'd6,
      CcVs = 4'd7,
      CcVc = 4'd8,
      CcHi = 4'd9,
      CcLs = 4'd10,
      CcGe = 4'd11,
      CcLt = 4'd12,
      CcGt = 4'd13,
      CcLe = 4'd14,
      CcNv = 4'd15
   } cc_e;

   // Flag word layout {V,C,N,Z}
   localparam int unsigned FLAG_Z = 0;
   localparam int unsigned FLAG_N = 1;
   localparam int unsigned FLAG_C = 2;
   localparam int unsigned FLAG_V = 3;

   // Returns 1 when the condition code holds for the given flag word
   function automatic logic cond_eval(input cc_e cc, input logic [3:0] flags);
      logic z;
      logic n;
      logic c;
      logic v;
      logic res;
      z   = flags[FLAG_Z];
      n   = flags[FLAG_N];
      c   = flags[FLAG_C];
      v   = flags[FLAG_V];
      res = 1'b0;
      unique case (cc)
         CcAl: res = 1'b1;
         CcEq: res = z;
         CcNe: res = ~z;
         CcCs: res = c;
         CcCc: res = ~c;
         CcMi: res = n;
         CcPl: res = ~n;
         CcVs: res = v;
         CcVc: res = ~v;
         CcHi: res = c & ~z;
         CcLs: res = ~c | z;
         CcGe: res = (n == v);
         CcLt: res = (n != v);
         CcGt: res = ~z & (n == v);
         CcLe: res = z | (n != v);
         CcNv: res = 1'b0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/amber_ras.sv
// Circular return-address stack. When full, a push overwrites the oldest
// entry and the occupancy count saturates at DEPTH.
module amber_ras
   import amber_branch_unit_p_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 48,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] push_data,
   output logic [WIDTH-1:0] top_data,
   output logic [CNT_W-1:0] count,
   output logic             underflow
);

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] ptr_q;    // next slot to write
   logic [CNT_W-1:0] count_q;
   logic [PTR_W-1:0] top_idx;
   logic             empty;

   // Top-of-stack read and underflow detect
   always_comb begin
      top_idx   = ptr_q - PTR_W'(1);
      top_data  = mem_q[top_idx];
      empty     = (count_q == '0);
      underflow = pop & ~push & empty;
      count     = count_q;
   end

   // Stack pointer, occupancy and storage update
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q   <= '{default: '0};
         ptr_q   <= '0;
         count_q <= '0;
      end else if (push) begin
         mem_q[ptr_q] <= push_data;
         ptr_q        <= ptr_q + PTR_W'(1);
         if (count_q != FULL_CNT) begin
            count_q <= count_q + CNT_W'(1);
         end
      end else if (pop && !empty) begin
         ptr_q   <= top_idx;
         count_q <= count_q - CNT_W'(1);
      end
   end

endmodule

// File: rtl/amber_branch_unit_p.sv
// Branch-resolution unit for the amber execute stage: condition evaluation,
// absolute/PC-relative target generation, uimm banks and a return-address stack.
module amber_branch_unit_p
   import amber_branch_unit_p_pkg::*;
#(
   parameter int unsigned ADDR_W    = 48,
   parameter int unsigned DATA_W    = 24,
   parameter int unsigned IMM_W     = 12,
   parameter int unsigned IMML_W    = 16,
   parameter int unsigned RAS_DEPTH = 8,
   localparam int unsigned NBANK      = ADDR_W / IMM_W - 1,
   localparam int unsigned BANK_SEL_W = (NBANK > 1) ? $clog2(NBANK) : 1,
   localparam int unsigned CNT_W      = $clog2(RAS_DEPTH) + 1
) (
   input  logic                  iw_clk,
   input  logic                  iw_rst,
   input  logic                  iw_valid,
   input  logic [2:0]            iw_op,
   input  logic [3:0]            iw_cc,
   input  logic [3:0]            iw_flags,
   input  logic [ADDR_W-1:0]     iw_pc,
   input  logic [BANK_SEL_W-1:0] iw_bank_sel,
   input  logic [IMM_W-1:0]      iw_imm,
   input  logic [IMML_W-1:0]     iw_imml,
   input  logic [DATA_W-1:0]     iw_reg_val,
   input  logic                  iw_stall,
   input  logic                  iw_flush,
   output logic                  ow_branch_taken,
   output logic [ADDR_W-1:0]     ow_branch_pc,
   output logic [ADDR_W-1:0]     ow_link_pc,
   output logic                  ow_ras_underflow,
   output logic [CNT_W-1:0]      ow_ras_count
);

   localparam logic [BANK_SEL_W:0] NBANK_L = (BANK_SEL_W + 1)'(NBANK);

   op_e              op;
   logic             act;
   logic             cond;
   logic             sel_ok;
   logic             ras_push;
   logic             ras_pop;
   logic             ras_underflow;
   logic [ADDR_W-1:0] ras_top;
   logic [ADDR_W-1:0] pc_plus1;
   logic [ADDR_W-1:0] jcc_target;
   logic [ADDR_W-1:0] sext_reg;
   logic [ADDR_W-1:0] sext_imm;
   logic [ADDR_W-1:0] sext_imml;

   logic [IMM_W-1:0] bank_q [NBANK];
   logic [IMM_W-1:0] bank_d [NBANK];
   logic             taken_q, taken_d;
   logic [ADDR_W-1:0] branch_pc_q, branch_pc_d;
   logic [ADDR_W-1:0] link_pc_q, link_pc_d;
   logic             underflow_q, underflow_d;

   // Operand decode: condition, sign extensions and the absolute jump target
   always_comb begin
      op        = op_e'(iw_op);
      act       = iw_valid & ~iw_stall & ~iw_flush;
      cond      = cond_eval(cc_e'(iw_cc), iw_flags);
      sel_ok    = ({1'b0, iw_bank_sel} < NBANK_L);
      pc_plus1  = iw_pc + ADDR_W'(1);
      sext_reg  = {{(ADDR_W - DATA_W){iw_reg_val[DATA_W-1]}}, iw_reg_val};
      sext_imm  = {{(ADDR_W - IMM_W){iw_imm[IMM_W-1]}}, iw_imm};
      sext_imml = {{(ADDR_W - IMML_W){iw_imml[IMML_W-1]}}, iw_imml};
      jcc_target = '0;
      jcc_target[IMM_W-1:0] = iw_imm;
      for (int i = 0; i < NBANK; i++) begin
         jcc_target[IMM_W*(i+1) +: IMM_W] = bank_q[i];
      end
      ras_push = act & (op == OpCall);
      ras_pop  = act & (op == OpRet);
   end

   // Next-state for registered outputs and uimm banks
   always_comb begin
      bank_d      = bank_q;
      taken_d     = 1'b0;
      branch_pc_d = branch_pc_q;
      link_pc_d   = link_pc_q;
      underflow_d = 1'b0;
      if (iw_flush) begin
         branch_pc_d = '0;
         link_pc_d   = '0;
      end else if (iw_valid) begin
         unique case (op)
            OpNop: ;
            OpLui: begin
               if (sel_ok) begin
                  bank_d[iw_bank_sel] = iw_imm;
               end
            end
            OpJcc: begin
               taken_d     = cond;
               branch_pc_d = jcc_target;
            end
            OpBccr: begin
               taken_d     = cond;
               branch_pc_d = iw_pc + sext_reg;
            end
            OpBcco: begin
               taken_d     = cond;
               branch_pc_d = iw_pc + sext_imm;
            end
            OpBal: begin
               taken_d     = 1'b1;
               branch_pc_d = iw_pc + sext_imml;
            end
            OpCall: begin
               taken_d     = 1'b1;
               branch_pc_d = iw_pc + sext_imml;
               link_pc_d   = pc_plus1;
            end
            OpRet: begin
               if (ras_underflow) begin
                  underflow_d = 1'b1;
               end else begin
                  taken_d     = 1'b1;
                  branch_pc_d = ras_top;
               end
            end
         endcase
      end
   end

   // State registers; stall freezes everything
   always_ff @(posedge iw_clk) begin
      if (iw_rst) begin
         bank_q      <= '{default: '0};
         taken_q     <= 1'b0;
         branch_pc_q <= '0;
         link_pc_q   <= '0;
         underflow_q <= 1'b0;
      end else if (!iw_stall) begin
         bank_q      <= bank_d;
         taken_q     <= taken_d;
         branch_pc_q <= branch_pc_d;
         link_pc_q   <= link_pc_d;
         underflow_q <= underflow_d;
      end
   end

   amber_ras #(
      .DEPTH (RAS_DEPTH),
      .WIDTH (ADDR_W)
   ) u_ras (
      .clk       (iw_clk),
      .rst       (iw_rst),
      .push      (ras_push),
      .pop       (ras_pop),
      .push_data (pc_plus1),
      .top_data  (ras_top),
      .count     (ow_ras_count),
      .underflow (ras_underflow)
   );

   // Output drive from registered state
   always_comb begin
      ow_branch_taken  = taken_q;
      ow_branch_pc     = branch_pc_q;
      ow_link_pc       = link_pc_q;
      ow_ras_underflow = underflow_q;
   end

endmodule

// File: tb/tb_amber_branch_unit_p.sv
// Directed self-checking bench for amber_branch_unit_p.
module tb_amber_branch_unit_p;

   logic        clk;
   logic        rst;
   logic        valid;
   logic [2:0]  op;
   logic [3:0]  cc;
   logic [3:0]  flags;
   logic [47:0] pc;
   logic [1:0]  bank_sel;
   logic [11:0] imm;
   logic [15:0] imml;
   logic [23:0] reg_val;
   logic        stall;
   logic        flush;
   logic        taken;
   logic [47:0] branch_pc;
   logic [47:0] link_pc;
   logic        underflow;
   logic [3:0]  ras_count;

   int n_chk;
   int n_fail;

   amber_branch_unit_p dut (
      .iw_clk           (clk),
      .iw_rst           (rst),
      .iw_valid         (valid),
      .iw_op            (op),
      .iw_cc            (cc),
      .iw_flags         (flags),
      .iw_pc            (pc),
      .iw_bank_sel      (bank_sel),
      .iw_imm           (imm),
      .iw_imml          (imml),
      .iw_reg_val       (reg_val),
      .iw_stall         (stall),
      .iw_flush         (flush),
      .ow_branch_taken  (taken),
      .ow_branch_pc     (branch_pc),
      .ow_link_pc       (link_pc),
      .ow_ras_underflow (underflow),
      .ow_ras_count     (ras_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] o, input logic [3:0] c, input logic [47:0] p,
                        input logic [11:0] i, input logic [15:0] il, input logic [23:0] rv,
                        input logic [1:0] sel);
      valid    = 1'b1;
      op       = o;
      cc       = c;
      pc       = p;
      imm      = i;
      imml     = il;
      reg_val  = rv;
      bank_sel = sel;
      tick();
      valid = 1'b0;
   endtask

   initial begin
      n_chk = 0;
      n_fail = 0;
      rst = 1'b1; valid = 1'b0; op = '0; cc = '0; flags = 4'b0001; pc = '0;
      bank_sel = '0; imm = '0; imml = '0; reg_val = '0; stall = 1'b0; flush = 1'b0;
      tick();
      tick();
      check_eq("rst_taken", {63'd0, taken}, 64'd0);
      check_eq("rst_pc", {16'd0, branch_pc}, 64'd0);
      check_eq("rst_link", {16'd0, link_pc}, 64'd0);
      check_eq("rst_uf", {63'd0, underflow}, 64'd0);
      check_eq("rst_cnt", {60'd0, ras_count}, 64'd0);
      rst = 1'b0;

      // 1: LUI banks then absolute JCC
      issue(3'd1, 4'd0, 48'h0, 12'h012, 16'h0, 24'h0, 2'd2);
      check_eq("lui_taken", {63'd0, taken}, 64'd0);
      issue(3'd1, 4'd0, 48'h0, 12'h345, 16'h0, 24'h0, 2'd1);
      issue(3'd1, 4'd0, 48'h0, 12'h678, 16'h0, 24'h0, 2'd0);
      issue(3'd2, 4'd1, 48'h0, 12'h9AB, 16'h0, 24'h0, 2'd0);
      check_eq("jcc_taken", {63'd0, taken}, 64'd1);
      check_eq("jcc_pc", {16'd0, branch_pc}, 64'h0123456789AB);
      tick();
      check_eq("nop_taken", {63'd0, taken}, 64'd0);
      check_eq("nop_pc_hold", {16'd0, branch_pc}, 64'h0123456789AB);

      // 2: relative branches
      issue(3'd5, 4'd0, 48'h1000, 12'h0, 16'hFFF8, 24'h0, 2'd0);
      check_eq("bal_taken", {63'd0, taken}, 64'd1);
      check_eq("bal_pc", {16'd0, branch_pc}, 64'hFF8);
      issue(3'd4, 4'd0, 48'h200, 12'h005, 16'h0, 24'h0, 2'd0);
      check_eq("bcco_pc", {16'd0, branch_pc}, 64'h205);
      check_eq("bcco_taken", {63'd0, taken}, 64'd1);
      issue(3'd3, 4'd2, 48'h300, 12'h0, 16'h0, 24'hFFFFFE, 2'd0);
      check_eq("bccr_ne_taken", {63'd0, taken}, 64'd0);
      check_eq("bccr_pc", {16'd0, branch_pc}, 64'h2FE);
      // condition codes on other flag patterns
      flags = 4'b0010;  // N=1, V=0
      issue(3'd4, 4'd12, 48'h400, 12'h001, 16'h0, 24'h0, 2'd0);
      check_eq("cc_lt", {63'd0, taken}, 64'd1);
      issue(3'd4, 4'd11, 48'h400, 12'h001, 16'h0, 24'h0, 2'd0);
      check_eq("cc_ge", {63'd0, taken}, 64'd0);
      issue(3'd4, 4'd14, 48'h400, 12'h001, 16'h0, 24'h0, 2'd0);
      check_eq("cc_le", {63'd0, taken}, 64'd1);
      flags = 4'b0100;  // C=1, Z=0
      issue(3'd4, 4'd9, 48'h400, 12'h001, 16'h0, 24'h0, 2'd0);
      check_eq("cc_hi", {63'd0, taken}, 64'd1);
      issue(3'd4, 4'd10, 48'h400, 12'h001, 16'h0, 24'h0, 2'd0);
      check_eq("cc_ls", {63'd0, taken}, 64'd0);
      issue(3'd4, 4'd15, 48'h400, 12'h001, 16'h0, 24'h0, 2'd0);
      check_eq("cc_nv", {63'd0, taken}, 64'd0);
      flags = 4'b0001;

      // 3: CALL x3, RET x4
      issue(3'd6, 4'd0, 48'h10, 12'h0, 16'h0100, 24'h0, 2'd0);
      check_eq("call_pc", {16'd0, branch_pc}, 64'h110);
      check_eq("call_link", {16'd0, link_pc}, 64'h11);
      check_eq("call_cnt", {60'd0, ras_count}, 64'd1);
      issue(3'd6, 4'd0, 48'h20, 12'h0, 16'h0100, 24'h0, 2'd0);
      issue(3'd6, 4'd0, 48'h30, 12'h0, 16'h0100, 24'h0, 2'd0);
      check_eq("call3_cnt", {60'd0, ras_count}, 64'd3);
      for (int k = 0; k < 3; k++) begin
         issue(3'd7, 4'd0, 48'h0, 12'h0, 16'h0, 24'h0, 2'd0);
         check_eq("ret_taken", {63'd0, taken}, 64'd1);
         check_eq("ret_pc", {16'd0, branch_pc}, 64'(48'h31 - 48'(k) * 48'h10));
         check_eq("ret_cnt", {60'd0, ras_count}, 64'(2 - k));
      end
      issue(3'd7, 4'd0, 48'h0, 12'h0, 16'h0, 24'h0, 2'd0);
      check_eq("uf_taken", {63'd0, taken}, 64'd0);
      check_eq("uf_pulse", {63'd0, underflow}, 64'd1);
      check_eq("uf_cnt", {60'd0, ras_count}, 64'd0);
      tick();
      check_eq("uf_clear", {63'd0, underflow}, 64'd0);

      // 4: overflow the RAS
      for (int k = 1; k <= 9; k++) begin
         issue(3'd6, 4'd0, 48'(k), 12'h0, 16'h0, 24'h0, 2'd0);
      end
      check_eq("sat_cnt", {60'd0, ras_count}, 64'd8);
      for (int k = 0; k < 8; k++) begin
         issue(3'd7, 4'd0, 48'h0, 12'h0, 16'h0, 24'h0, 2'd0);
         check_eq("ovf_ret_pc", {16'd0, branch_pc}, 64'(10 - k));
         check_eq("ovf_ret_cnt", {60'd0, ras_count}, 64'(7 - k));
      end
      issue(3'd7, 4'd0, 48'h0, 12'h0, 16'h0, 24'h0, 2'd0);
      check_eq("ovf_uf", {63'd0, underflow}, 64'd1);
      check_eq("ovf_uf_taken", {63'd0, taken}, 64'd0);

      // 5: stall, flush, reset
      issue(3'd6, 4'd0, 48'h40, 12'h0, 16'h0, 24'h0, 2'd0);
      stall = 1'b1;
      issue(3'd6, 4'd0, 48'h50, 12'h0, 16'h0, 24'h0, 2'd0);
      stall = 1'b0;
      check_eq("stall_cnt", {60'd0, ras_count}, 64'd1);
      check_eq("stall_link", {16'd0, link_pc}, 64'h41);
      check_eq("stall_pc", {16'd0, branch_pc}, 64'h40);
      check_eq("stall_taken", {63'd0, taken}, 64'd1);
      issue(3'd7, 4'd0, 48'h0, 12'h0, 16'h0, 24'h0, 2'd0);
      check_eq("stall_ret_pc", {16'd0, branch_pc}, 64'h41);
      flush = 1'b1;
      issue(3'd2, 4'd1, 48'h0, 12'h9AB, 16'h0, 24'h0, 2'd0);
      check_eq("flush_taken", {63'd0, taken}, 64'd0);
      check_eq("flush_pc", {16'd0, branch_pc}, 64'd0);
      issue(3'd1, 4'd0, 48'h0, 12'hFFF, 16'h0, 24'h0, 2'd0);
      flush = 1'b0;
      issue(3'd2, 4'd1, 48'h0, 12'h9AB, 16'h0, 24'h0, 2'd0);
      check_eq("flush_banks", {16'd0, branch_pc}, 64'h0123456789AB);
      issue(3'd6, 4'd0, 48'h60, 12'h0, 16'h0, 24'h0, 2'd0);
      issue(3'd6, 4'd0, 48'h70, 12'h0, 16'h0, 24'h0, 2'd0);
      check_eq("pre_rst_cnt", {60'd0, ras_count}, 64'd2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("mid_rst_cnt", {60'd0, ras_count}, 64'd0);
      check_eq("mid_rst_pc", {16'd0, branch_pc}, 64'd0);
      check_eq("mid_rst_link", {16'd0, link_pc}, 64'd0);
      check_eq("mid_rst_taken", {63'd0, taken}, 64'd0);
      // out-of-range bank select is ignored; banks read back zero after reset
      issue(3'd1, 4'd0, 48'h0, 12'hABC, 16'h0, 24'h0, 2'd3);
      issue(3'd2, 4'd0, 48'h0, 12'h001, 16'h0, 24'h0, 2'd0);
      check_eq("banks_zero", {16'd0, branch_pc}, 64'h1);

      // 6: wrap-around
      issue(3'd4, 4'd0, 48'hFFFFFFFFFFFE, 12'h004, 16'h0, 24'h0, 2'd0);
      check_eq("wrap_bcco", {16'd0, branch_pc}, 64'h2);
      issue(3'd6, 4'd0, 48'hFFFFFFFFFFFF, 12'h0, 16'h0, 24'h0, 2'd0);
      check_eq("wrap_link", {16'd0, link_pc}, 64'h0);
      issue(3'd7, 4'd0, 48'h0, 12'h0, 16'h0, 24'h0, 2'd0);
      check_eq("wrap_ret_taken", {63'd0, taken}, 64'd1);
      check_eq("wrap_ret_pc", {16'd0, branch_pc}, 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
